lookup_table_pp: RTL and testbench
==================================

// Module: lookup_table_pp
// PURPOSE
//  Parametrised, double-buffered (ping-pong) multi-channel LUT for the NPU activation/quant path.
//  Up to NCH lanes read the active bank every cycle, with registered outputs and a valid flag.
//  The host loads the shadow bank in the background. Swap is handshaked, so tables change with no read glitch.
// PARAMETERS
//  DW   24  entry width (bits)
//  AW   4   address width; DEPTH = 2**AW entries per bank
//  NCH  32  number of parallel read lanes
// PORTS
//  clka           in   1       clock; all state updates on rising edge
//  rst            in   1       asynchronous, active-low reset
//  load_start     in   1       pulse: begin shadow-bank load, clear written-mask
//  wr_en          in   1       shadow-bank write strobe
//  wr_addr        in   AW      shadow-bank write address
//  wr_data        in   DW      shadow-bank write data
//  shadow_full    out  1       every shadow address written since last load_start
//  swap_req       in   1       pulse: make shadow bank active
//  swap_ack       out  1       1-cycle pulse, swap taken
//  err            out  1       1-cycle pulse, illegal write or swap request dropped
//  bank_sel       out  1       index of the active bank
//  rd_valid       in   1       read request, all lanes
//  rd_addr        in   NCH*AW  lane i address = [i*AW +: AW]
//  rd_data_valid  out  1       rd_valid delayed 1 cycle
//  rd_data        out  NCH*DW  lane i data = [i*DW +: DW]
//  parity_err     out  NCH     per-lane parity fail (LUT_PARITY_EN only)
// BEHAVIOUR
//  Reset: both banks all-zero, bank_sel=0, FSM=IDLE, mask=0. All outputs are 0.
//  Read: when rd_valid=1 at edge N, rd_data holds active[rd_addr] (bank_sel before edge N) after N.
//    rd_data_valid=1 after N. When rd_valid=0, rd_data holds its last value and rd_data_valid=0.
//  Lanes are independent. Any lanes may read the same address.
//  Load FSM: IDLE -> LOAD on load_start. LOAD -> FULL at the edge that sets the last mask bit.
//    FULL -> IDLE on swap. load_start in LOAD or FULL clears the mask and re-enters LOAD.
//  Write: accepted only in LOAD (incl. FULL). Writes shadow[wr_addr] and sets mask[wr_addr].
//    A rewrite of the same address overwrites the entry; the mask is unchanged.
//    wr_en in IDLE is dropped and err pulses. wr_en with load_start in the same cycle: write dropped, no err.
//  shadow_full = (FSM==FULL). It is registered, so it rises the cycle after the final write.
//  Swap: swap_req in FULL toggles bank_sel at the same edge, pulses swap_ack, and FSM goes to IDLE.
//    swap_req in IDLE or LOAD is ignored and err pulses.
//    swap_req with load_start in FULL: swap wins and load_start is dropped.
//  Read with swap at the same edge: the read returns the OLD bank. The next read sees the new bank.
//  Read and write never touch the same bank, so there are no read/write hazards.
//  After swap the new shadow (old active) keeps stale contents until reloaded.
//  Reset mid-load: load is abandoned, banks are zeroed, FSM returns to IDLE.
// CONFIGURATION
//  LUT_PARITY_EN defined: each entry stores an extra even-parity bit computed on write.
//    Each lane checks parity on read. parity_err[i] is registered and aligned with rd_data_valid.
//    Reset clears all stored parity bits to 0 (even parity of zero data).
//  Not defined: no parity storage. parity_err is tied to 0. The port is kept for a uniform interface.
// STRUCTURE
//  Package lut_pkg: FSM state encoding (LUT_IDLE=2'd0, LUT_LOAD=2'd1, LUT_FULL=2'd2), default DW/AW/NCH.
//  Sub-module lut_bank: one DEPTH x DW(+1) register bank.
//    It has a write port, NCH combinational read ports, and async reset clear.
//    Two instances are used. Top holds the FSM, mask, bank_sel and output registers.
// TESTING
//  1 Reset, then read all 32 lanes at addr 0..15 -> rd_data all 0, rd_data_valid 1 cycle after rd_valid.
//  2 load_start, write k->0x100000+k for k=0..15 -> shadow_full rises after the 16th write.
//    Then swap_req -> swap_ack=1, bank_sel=1, and a read at addr 5 returns 0x100005.
//  3 Read and swap_req at the same edge -> that read returns the old value 0.
//    The read one cycle later returns 0x100005.
//  4 swap_req after only 15 writes -> err=1, no swap_ack, bank_sel unchanged.
//    wr_en in IDLE -> err=1, and a later load shows the entry unchanged.
//  5 Assert rst during LOAD after 8 writes -> FSM IDLE, shadow_full 0, bank_sel 0.
//    Reload plus swap then returns only the new data.
//  6 (LUT_PARITY_EN) Force a single bit flip in a stored entry -> parity_err[i]=1 only for lanes reading it.

Source files
------------

// File: rtl/lut_pkg.sv
// ----------------------------------------------------------------------------
// lut_pkg
//   Shared definitions for the ping-pong lookup table: load FSM state
//   encoding and default geometry (entry width, address width, lane count).
//   Optional build macro used by the LUT files: LUT_PARITY_EN.
// ----------------------------------------------------------------------------
package lut_pkg;

    typedef enum logic [1:0] {
        LUT_IDLE = 2'd0,
        LUT_LOAD = 2'd1,
        LUT_FULL = 2'd2
    } lut_state_e;

    localparam int LUT_DW_DEF  = 24;
    localparam int LUT_AW_DEF  = 4;
    localparam int LUT_NCH_DEF = 32;

endpackage : lut_pkg

// File: rtl/lut_bank.sv
// ----------------------------------------------------------------------------
// lut_bank
//   One DEPTH x EW register bank with a single write port and NCH
//   combinational read ports. The asynchronous active-low reset clears every
//   entry (including the parity bit when EW carries one).
// Ports
//   clka     in   1        clock
//   rst      in   1        asynchronous, active-low reset
//   wr_en    in   1        write strobe
//   wr_addr  in   AW       write address
//   wr_data  in   EW       write data (entry plus optional parity bit)
//   rd_addr  in   NCH*AW   lane i address = [i*AW +: AW]
//   rd_data  out  NCH*EW   lane i entry   = [i*EW +: EW], combinational
// Build macro: LUT_PARITY_EN (only affects EW chosen by the parent).
// ----------------------------------------------------------------------------
module lut_bank #(
    parameter int EW  = 24,
    parameter int AW  = 4,
    parameter int NCH = 32
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [EW-1:0]     wr_data,
    input  logic [NCH*AW-1:0] rd_addr,
    output logic [NCH*EW-1:0] rd_data
);

    localparam int DEPTH = 2 ** AW;

    logic [EW-1:0] mem [DEPTH];

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NCH; i++) begin
            rd_data[i*EW +: EW] = mem[rd_addr[i*AW +: AW]];
        end
    end

endmodule : lut_bank

// File: rtl/lookup_table_pp.sv
// ----------------------------------------------------------------------------
// lookup_table_pp
//   Double-buffered (ping-pong) multi-lane LUT. NCH lanes read the active
//   bank every cycle into registered outputs; the host fills the shadow bank
//   in the background and swaps it in with a handshake.
// Ports
//   clka           in   1       clock
//   rst            in   1       asynchronous, active-low reset
//   load_start     in   1       begin shadow load, clear written-mask
//   wr_en          in   1       shadow write strobe
//   wr_addr        in   AW      shadow write address
//   wr_data        in   DW      shadow write data
//   shadow_full    out  1       every shadow address written since load_start
//   swap_req       in   1       make shadow bank active
//   swap_ack       out  1       1-cycle pulse, swap taken
//   err            out  1       1-cycle pulse, illegal write/swap dropped
//   bank_sel       out  1       index of the active bank
//   rd_valid       in   1       read request, all lanes
//   rd_addr        in   NCH*AW  lane addresses
//   rd_data_valid  out  1       rd_valid delayed one cycle
//   rd_data        out  NCH*DW  lane data
//   parity_err     out  NCH     per-lane parity fail
// Build macro: LUT_PARITY_EN adds an even-parity bit per entry and per-lane
//   checking; without it parity_err is tied to 0.
// ----------------------------------------------------------------------------
module lookup_table_pp
    import lut_pkg::*;
#(
    parameter int DW  = LUT_DW_DEF,
    parameter int AW  = LUT_AW_DEF,
    parameter int NCH = LUT_NCH_DEF
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              load_start,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DW-1:0]     wr_data,
    output logic              shadow_full,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              err,
    output logic              bank_sel,
    input  logic              rd_valid,
    input  logic [NCH*AW-1:0] rd_addr,
    output logic              rd_data_valid,
    output logic [NCH*DW-1:0] rd_data,
    output logic [NCH-1:0]    parity_err
);

    localparam int DEPTH = 2 ** AW;
`ifdef LUT_PARITY_EN
    localparam int EW = DW + 1;
`else
    localparam int EW = DW;
`endif

    lut_state_e              state, state_nx;
    logic [DEPTH-1:0]        mask, mask_nx, wr_onehot;
    logic                    wr_accept, swap_take, err_nx;
    logic [EW-1:0]           wr_entry;
    logic [NCH*EW-1:0]       rd_bank0, rd_bank1, rd_active_p0;
    logic [NCH*DW-1:0]       lane_data_p0;

`ifdef LUT_PARITY_EN
    assign wr_entry = {^wr_data, wr_data};
`else
    assign wr_entry = wr_data;
`endif

    // Writes always target the bank that is not being read.
    lut_bank #(.EW(EW), .AW(AW), .NCH(NCH)) u_bank0 (
        .clka    (clka),
        .rst     (rst),
        .wr_en   (wr_accept & bank_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_entry),
        .rd_addr (rd_addr),
        .rd_data (rd_bank0)
    );

    lut_bank #(.EW(EW), .AW(AW), .NCH(NCH)) u_bank1 (
        .clka    (clka),
        .rst     (rst),
        .wr_en   (wr_accept & ~bank_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_entry),
        .rd_addr (rd_addr),
        .rd_data (rd_bank1)
    );

    // Load FSM: a write coinciding with load_start is dropped silently so the
    // fresh load starts from a clean mask.
    always_comb begin
        state_nx  = state;
        mask_nx   = mask;
        swap_take = 1'b0;
        wr_onehot = '0;
        wr_onehot[wr_addr] = 1'b1;
        wr_accept = wr_en && (state != LUT_IDLE) && !load_start;
        err_nx    = (wr_en && (state == LUT_IDLE) && !load_start) ||
                    (swap_req && (state != LUT_FULL));
        case (state)
            LUT_IDLE: begin
                if (load_start) begin
                    state_nx = LUT_LOAD;
                    mask_nx  = '0;
                end
            end
            LUT_LOAD: begin
                if (load_start) begin
                    mask_nx = '0;
                end else if (wr_accept) begin
                    mask_nx = mask | wr_onehot;
                    if (&mask_nx) state_nx = LUT_FULL;
                end
            end
            LUT_FULL: begin
                // Swap has priority over a simultaneous load_start.
                if (swap_req) begin
                    swap_take = 1'b1;
                    state_nx  = LUT_IDLE;
                end else if (load_start) begin
                    state_nx = LUT_LOAD;
                    mask_nx  = '0;
                end else if (wr_accept) begin
                    mask_nx = mask | wr_onehot;
                end
            end
            default: begin
                state_nx = LUT_IDLE;
                mask_nx  = '0;
            end
        endcase
    end

    assign shadow_full = (state == LUT_FULL);

    // Read stage p0: select the active bank before the swap edge takes effect.
    always_comb begin
        rd_active_p0 = bank_sel ? rd_bank1 : rd_bank0;
        lane_data_p0 = '0;
        for (int i = 0; i < NCH; i++) begin
            lane_data_p0[i*DW +: DW] = rd_active_p0[i*EW +: DW];
        end
    end

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            state         <= LUT_IDLE;
            mask          <= '0;
            bank_sel      <= 1'b0;
            swap_ack      <= 1'b0;
            err           <= 1'b0;
            rd_data_valid <= 1'b0;
            rd_data       <= '0;
        end else begin
            state         <= state_nx;
            mask          <= mask_nx;
            bank_sel      <= bank_sel ^ swap_take;
            swap_ack      <= swap_take;
            err           <= err_nx;
            rd_data_valid <= rd_valid;
            if (rd_valid) rd_data <= lane_data_p0;
        end
    end

`ifdef LUT_PARITY_EN
    logic [NCH-1:0] par_chk_p0;

    always_comb begin
        par_chk_p0 = '0;
        for (int i = 0; i < NCH; i++) begin
            par_chk_p0[i] = ^rd_active_p0[i*EW +: EW];
        end
    end

    // Registered alongside rd_data_valid; cleared on cycles without a read.
    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            parity_err <= '0;
        end else begin
            parity_err <= rd_valid ? par_chk_p0 : '0;
        end
    end
`else
    assign parity_err = '0;
`endif

endmodule : lookup_table_pp

// File: tb/tb_lookup_table_pp.sv
module tb_lookup_table_pp;

    localparam int DW    = 24;
    localparam int AW    = 4;
    localparam int NCH   = 32;
    localparam int DEPTH = 16;

    logic              clka = 1'b0;
    logic              rst = 1'b0;
    logic              load_start = 1'b0;
    logic              wr_en = 1'b0;
    logic [AW-1:0]     wr_addr = '0;
    logic [DW-1:0]     wr_data = '0;
    logic              shadow_full;
    logic              swap_req = 1'b0;
    logic              swap_ack;
    logic              err;
    logic              bank_sel;
    logic              rd_valid = 1'b0;
    logic [NCH*AW-1:0] rd_addr = '0;
    logic              rd_data_valid;
    logic [NCH*DW-1:0] rd_data;
    logic [NCH-1:0]    parity_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: two tables, which one is live, whether a load is open
    // and which addresses it has seen.
    logic [DW-1:0]     mbank [2][DEPTH];
    bit                msel;
    bit                mload;
    bit [DEPTH-1:0]    mwritten;
    logic [NCH*DW-1:0] exp_rd_data;
    bit                exp_valid, exp_ack, exp_err, exp_full;

    lookup_table_pp #(.DW(DW), .AW(AW), .NCH(NCH)) u_dut (
        .clka          (clka),
        .rst           (rst),
        .load_start    (load_start),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .shadow_full   (shadow_full),
        .swap_req      (swap_req),
        .swap_ack      (swap_ack),
        .err           (err),
        .bank_sel      (bank_sel),
        .rd_valid      (rd_valid),
        .rd_addr       (rd_addr),
        .rd_data_valid (rd_data_valid),
        .rd_data       (rd_data),
        .parity_err    (parity_err)
    );

    always #5 clka = ~clka;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < DEPTH; a++) mbank[b][a] = '0;
        msel = 0; mload = 0; mwritten = '0;
        exp_rd_data = '0; exp_valid = 0; exp_ack = 0; exp_err = 0; exp_full = 0;
    endtask

    // Apply current inputs for one clock, advance the model, return #1 after
    // the edge with the pulse inputs cleared.
    task automatic step();
        bit full_b  = mload && (&mwritten);
        bit old_sel = msel;
        bit wr_ok   = wr_en && mload && !load_start;
        if (rd_valid)
            for (int i = 0; i < NCH; i++)
                exp_rd_data[i*DW +: DW] = mbank[old_sel][rd_addr[i*AW +: AW]];
        exp_valid = rd_valid;
        exp_ack = 0;
        exp_err = wr_en && !mload && !load_start;
        if (swap_req && full_b) begin
            exp_ack = 1; msel = ~msel; mload = 0;
        end else begin
            if (swap_req) exp_err = 1;
            if (load_start) begin mload = 1; mwritten = '0; end
        end
        if (wr_ok) begin
            mbank[~old_sel][wr_addr] = wr_data;
            mwritten[wr_addr] = 1'b1;
        end
        exp_full = mload && (&mwritten);
        @(posedge clka);
        #1;
        load_start = 0; wr_en = 0; swap_req = 0; rd_valid = 0;
    endtask

    task automatic set_all_lanes(input int addr);
        for (int i = 0; i < NCH; i++) rd_addr[i*AW +: AW] = AW'(addr);
    endtask

    task automatic test_reset();
        rst = 0;
        model_reset();
        #2;
        n_tests++;
        if ({rd_data_valid, swap_ack, err, shadow_full, bank_sel} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 00000",
                     {rd_data_valid, swap_ack, err, shadow_full, bank_sel});
        end
        n_tests++;
        if (rd_data !== '0 || parity_err !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got nonzero rd_data/parity_err (par %h) required 0", parity_err);
        end
        rst = 1;
        @(posedge clka); #1;
    endtask

    task automatic test_read_zero();
        for (int k = 0; k < DEPTH; k++) begin
            for (int i = 0; i < NCH; i++) rd_addr[i*AW +: AW] = AW'((i + k) % DEPTH);
            rd_valid = 1;
            step();
            n_tests++;
            if (rd_data_valid !== 1'b1 || rd_data !== '0) begin
                n_fail++;
                $display("FAIL read_zero k=%0d: valid %b lane0 %h required valid 1 data 0",
                         k, rd_data_valid, rd_data[DW-1:0]);
            end
        end
        step();
        n_tests++;
        if (rd_data_valid !== 1'b0 || rd_data !== '0) begin
            n_fail++;
            $display("FAIL read_idle_hold: valid %b lane0 %h required valid 0 data 0",
                     rd_data_valid, rd_data[DW-1:0]);
        end
    endtask

    task automatic test_load();
        load_start = 1;
        step();
        for (int k = 0; k < DEPTH; k++) begin
            wr_en = 1; wr_addr = AW'(k); wr_data = DW'(24'h100000 + k);
            step();
            if (k == DEPTH - 2) begin
                n_tests++;
                if (shadow_full !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_early: shadow_full %b required 0", shadow_full);
                end
            end
        end
        n_tests++;
        if (shadow_full !== 1'b1) begin
            n_fail++;
            $display("FAIL full_after_16: shadow_full %b required 1", shadow_full);
        end
    endtask

    task automatic test_swap_same_edge();
        logic [NCH*DW-1:0] want;
        swap_req = 1; rd_valid = 1; set_all_lanes(5);
        step();
        n_tests++;
        if (swap_ack !== 1'b1 || bank_sel !== 1'b1 || shadow_full !== 1'b0) begin
            n_fail++;
            $display("FAIL swap_take: ack %b sel %b full %b required 1 1 0",
                     swap_ack, bank_sel, shadow_full);
        end
        n_tests++;
        if (rd_data !== '0) begin
            n_fail++;
            $display("FAIL swap_edge_old: lane0 %h required 0", rd_data[DW-1:0]);
        end
        rd_valid = 1; set_all_lanes(5);
        step();
        for (int i = 0; i < NCH; i++) want[i*DW +: DW] = 24'h100005;
        n_tests++;
        if (rd_data !== want || swap_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL swap_next_new: lane0 %h ack %b required 100005 ack 0",
                     rd_data[DW-1:0], swap_ack);
        end
    endtask

    task automatic test_errors();
        load_start = 1;
        step();
        for (int k = 0; k < DEPTH - 1; k++) begin
            wr_en = 1; wr_addr = AW'(k); wr_data = DW'($urandom);
            step();
        end
        swap_req = 1;
        step();
        n_tests++;
        if (err !== 1'b1 || swap_ack !== 1'b0 || bank_sel !== 1'b1) begin
            n_fail++;
            $display("FAIL swap_not_full: err %b ack %b sel %b required 1 0 1",
                     err, swap_ack, bank_sel);
        end
        wr_en = 1; wr_addr = AW'(DEPTH - 1); wr_data = DW'($urandom);
        step();
        swap_req = 1;
        step();
        n_tests++;
        if (swap_ack !== 1'b1 || bank_sel !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL swap_back: ack %b sel %b err %b required 1 0 0", swap_ack, bank_sel, err);
        end
        wr_en = 1; wr_addr = AW'(2); wr_data = 24'hABCDEF;
        step();
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_write_err: err %b required 1", err);
        end
        rd_valid = 1; set_all_lanes(2);
        step();
        n_tests++;
        if (rd_data !== exp_rd_data || rd_data[DW-1:0] === 24'hABCDEF || err !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_write_dropped: lane0 %h required %h err %b",
                     rd_data[DW-1:0], exp_rd_data[DW-1:0], err);
        end
        wr_en = 1; load_start = 1; wr_addr = AW'(0); wr_data = 24'h5A5A5A;
        step();
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL write_with_load: err %b required 0", err);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [NCH*DW-1:0] want;
        load_start = 1;
        step();
        for (int k = 0; k < 8; k++) begin
            wr_en = 1; wr_addr = AW'(k); wr_data = DW'(24'hEE0000 + k);
            step();
        end
        rst = 0;
        model_reset();
        #2;
        n_tests++;
        if (shadow_full !== 1'b0 || bank_sel !== 1'b0 || rd_data !== '0) begin
            n_fail++;
            $display("FAIL mid_load_reset: full %b sel %b lane0 %h required 0 0 0",
                     shadow_full, bank_sel, rd_data[DW-1:0]);
        end
        rst = 1;
        @(posedge clka); #1;
        swap_req = 1;
        step();
        n_tests++;
        if (err !== 1'b1 || swap_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset_idle: err %b ack %b required 1 0", err, swap_ack);
        end
        load_start = 1;
        step();
        for (int k = DEPTH - 1; k >= 0; k--) begin
            wr_en = 1; wr_addr = AW'(k); wr_data = DW'(24'h300000 | (k << 4));
            step();
        end
        swap_req = 1;
        step();
        for (int i = 0; i < NCH; i++) begin
            rd_addr[i*AW +: AW] = AW'(i % DEPTH);
            want[i*DW +: DW] = DW'(24'h300000 | ((i % DEPTH) << 4));
        end
        rd_valid = 1;
        step();
        n_tests++;
        if (rd_data !== want || bank_sel !== 1'b1) begin
            n_fail++;
            $display("FAIL reload_new_only: lane1 %h required %h sel %b",
                     rd_data[2*DW-1:DW], want[2*DW-1:DW], bank_sel);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            load_start = ($urandom_range(0, 199) == 0);
            wr_en      = ($urandom_range(0, 1) == 1);
            wr_addr    = AW'($urandom);
            wr_data    = DW'($urandom);
            swap_req   = ($urandom_range(0, 7) == 0);
            rd_valid   = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NCH; i++) rd_addr[i*AW +: AW] = AW'($urandom);
            step();
            n_tests++;
            if (rd_data_valid !== exp_valid || swap_ack !== exp_ack || err !== exp_err ||
                shadow_full !== exp_full || bank_sel !== msel) begin
                n_fail++;
                $display("FAIL rand_ctrl c=%0d: got v%b a%b e%b f%b s%b required v%b a%b e%b f%b s%b",
                         c, rd_data_valid, swap_ack, err, shadow_full, bank_sel,
                         exp_valid, exp_ack, exp_err, exp_full, msel);
            end
            n_tests++;
            if (rd_data !== exp_rd_data) begin
                n_fail++;
                for (int i = 0; i < NCH; i++)
                    if (rd_data[i*DW +: DW] !== exp_rd_data[i*DW +: DW]) begin
                        $display("FAIL rand_data c=%0d lane %0d: got %h required %h",
                                 c, i, rd_data[i*DW +: DW], exp_rd_data[i*DW +: DW]);
                        break;
                    end
            end
`ifndef LUT_PARITY_EN
            n_tests++;
            if (parity_err !== '0) begin
                n_fail++;
                $display("FAIL rand_parity c=%0d: got %h required 0", c, parity_err);
            end
`endif
        end
    endtask

`ifdef LUT_PARITY_EN
    task automatic test_parity();
        logic [NCH-1:0] want;
        if (msel) u_dut.u_bank1.mem[7][3] = ~u_dut.u_bank1.mem[7][3];
        else      u_dut.u_bank0.mem[7][3] = ~u_dut.u_bank0.mem[7][3];
        for (int i = 0; i < NCH; i++) begin
            rd_addr[i*AW +: AW] = (i % 2 == 0) ? AW'(7) : AW'(8);
            want[i] = (i % 2 == 0);
        end
        rd_valid = 1;
        step();
        n_tests++;
        if (parity_err !== want) begin
            n_fail++;
            $display("FAIL parity_flip: got %h required %h", parity_err, want);
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_read_zero();
        test_load();
        test_swap_same_edge();
        test_errors();
        test_reset_mid_load();
        test_random();
`ifdef LUT_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_lookup_table_pp
